cache_mem_responder: RTL
========================

Name: cache_mem_responder

Overview:
Memory-side responder for the cache refill protocol. It arbitrates between the I-cache and D-cache fill/write ports and owns a word-addressed 16-bit backing memory. It answers each accepted read with a fixed-latency pipelined data-valid pulse routed to the owning cache. It sits below both caches and replaces direct memory hookup.

Parameters:
LATENCY, 4, cycles from accepted read to mem_data_vld pulse (>=1)
ADDR_W, 15, word-address width; memory holds 2^ADDR_W 16-bit words indexed by addr[15:1]
MAX_BURST, 8, max requests accepted per ownership before forced release

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-low
i_read_req  in  1  I-cache read request for i_addr this cycle
i_addr  in  16  I-cache byte address; bit 0 ignored
i_stall  out  1  I request not accepted this cycle
i_mem_data_vld  out  1  mem_data is a response for I-cache
d_read_req  in  1  D-cache read request
d_wrt_mem  in  1  D-cache write request; mutually exclusive with d_read_req
d_addr  in  16  D-cache byte address
d_wdata  in  16  D-cache write data
d_stall  out  1  D request not accepted this cycle
d_mem_data_vld  out  1  mem_data is a response for D-cache
mem_data  out  16  shared response data

Behaviour:
- Reset (rst==0 at edge): state IDLE; pipeline valid bits cleared; last_owner=I; burst count 0; i_mem_data_vld=d_mem_data_vld=0, mem_data=0. In-flight reads are dropped, never answered. Memory contents are not cleared.
- A request is req_X = X_read_req | X_wrt_mem; I has no write.
- States:
  - IDLE: no owner; both stall signals are high whenever the matching request is high.
    - One requester: goes to OWN_X next cycle.
    - Both requesting: goes to OWN of the one not equal to last_owner, so D wins first after reset.
  - OWN_X: a request from X is accepted every cycle it is high (X_stall=0); the other port stalls.
    - Each accept increments burst count.
    - Goes to DRAIN when req_X drops or burst count reaches MAX_BURST. The MAX_BURST-th request is accepted; later ones stall.
    - On leaving OWN_X: last_owner=X, burst count cleared.
  - DRAIN: no accepts; both stall. Goes to IDLE when pipeline holds no valid entries. With LATENCY=1 and an empty pipe, DRAIN lasts one cycle.
- Arbitration takes one cycle: the first request in IDLE is stalled and accepted the following cycle.
- Accepted read: array[addr[15:1]] is sampled at accept and enters pipeline stage 1 tagged with the owner. At stage LATENCY it drives mem_data and pulses exactly one owner's vld for one cycle. Back-to-back accepts give back-to-back vld pulses, in order.
- Accepted write: array updated at accept edge. No response, no pipeline entry. A read accepted the next cycle returns the new data.
- Stall outputs are combinational from state, requests and burst count.
- mem_data holds its last value when no vld is asserted.
- A vld pulse is never asserted to a non-owner; both vld are never high together.
- Address arithmetic: word index = addr[ADDR_W:1]; higher address bits are ignored (wrap).

Decomposition:
- Shared package: state encoding (IDLE, OWN_I, OWN_D, DRAIN), owner encoding (I=0, D=1), default LATENCY, default MAX_BURST.
- One sub-module, resp_pipe: LATENCY-deep shift register of {valid, owner, data} with an any_valid output, used for DRAIN exit.
- Arbiter FSM and memory array live in the top module.

Test Plan:
- I fill: i_read_req high 8 cycles, addresses 0x0100..0x010E, array preloaded word[i]=0xA000+i.
  - Accepts start at cycle 1.
  - i_mem_data_vld high for cycles 5..12 with data 0xA080..0xA087.
  - DRAIN, then IDLE at cycle 13.
- Collision after reset: both requests rise at cycle 0.
  - D owns first, I stalls.
  - I is granted only after D's drain completes.
  - No d_mem_data_vld during I's burst.
- Write then read: D writes 0xBEEF to 0x0040, then reads 0x0040 next cycle → d_mem_data_vld 4 cycles later with 0xBEEF.
- Burst cap: I holds request 12 cycles.
  - Exactly 8 accepted, then i_stall=1.
  - After drain, pending D is granted before I, since last_owner=I.
- Reset mid-burst: rst=0 on cycle 3 of an I fill.
  - No vld pulses afterwards.
  - State IDLE, outputs 0.
  - Memory contents unchanged, checked by a later read.
- Wrap: read addr 0xFFFE with ADDR_W=15 → returns word 0x7FFF; LATENCY=1 build returns data the next cycle.

Source files
------------

// File: rtl/cache_mem_responder_pkg.sv
// Shared types and default parameters for the cache memory responder.
// Both the arbiter top and the response pipeline import these.
package cache_mem_responder_pkg;

    localparam int unsigned DEF_LATENCY   = 4;
    localparam int unsigned DEF_ADDR_W    = 15;
    localparam int unsigned DEF_MAX_BURST = 8;
    localparam int unsigned DATA_W        = 16;

    typedef enum logic [1:0] {
        StIdle,
        StOwnI,
        StOwnD,
        StDrain
    } state_e;

    typedef enum logic {
        OwnerI = 1'b0,
        OwnerD = 1'b1
    } owner_e;

endpackage

// File: rtl/cache_mem_responder_resp_pipe.sv
// Fixed-latency shift register of {valid, owner, data} for read responses.
// The last stage drives the response outputs and holds its data between pulses.
module cache_mem_responder_resp_pipe
    import cache_mem_responder_pkg::*;
#(
    parameter int unsigned LATENCY = DEF_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  owner_e            in_owner,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_vld,
    output owner_e            out_owner,
    output logic [DATA_W-1:0] out_data,
    output logic              any_valid
);

    logic [LATENCY-1:0] valid_q, valid_d;
    owner_e             owner_q [LATENCY];
    owner_e             owner_d [LATENCY];
    logic [DATA_W-1:0]  data_q  [LATENCY];
    logic [DATA_W-1:0]  data_d  [LATENCY];

    // Payload only advances behind a valid entry, so the output stage keeps
    // the last delivered word when the pipe runs dry.
    always_comb begin
        valid_d    = valid_q;
        owner_d    = owner_q;
        data_d     = data_q;
        valid_d[0] = in_vld;
        if (in_vld) begin
            owner_d[0] = in_owner;
            data_d[0]  = in_data;
        end
        for (int k = 1; k < LATENCY; k++) begin
            valid_d[k] = valid_q[k-1];
            if (valid_q[k-1]) begin
                owner_d[k] = owner_q[k-1];
                data_d[k]  = data_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                owner_q[k] <= OwnerI;
                data_q[k]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            owner_q <= owner_d;
            data_q  <= data_d;
        end
    end

    assign out_vld   = valid_q[LATENCY-1];
    assign out_owner = owner_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];

    // Entries that will still be in flight after this cycle's output pulse.
    if (LATENCY > 1) begin : g_inflight
        assign any_valid = |valid_q[LATENCY-2:0];
    end else begin : g_no_inflight
        assign any_valid = 1'b0;
    end

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder: arbitrates I/D cache ports over a shared backing
// memory and returns reads through a fixed-latency pipeline.
module cache_mem_responder
    import cache_mem_responder_pkg::*;
#(
    parameter int unsigned LATENCY   = DEF_LATENCY,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read_req,
    input  logic [15:0]       i_addr,
    output logic              i_stall,
    output logic              i_mem_data_vld,
    input  logic              d_read_req,
    input  logic              d_wrt_mem,
    input  logic [15:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_stall,
    output logic              d_mem_data_vld,
    output logic [DATA_W-1:0] mem_data
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    state_e             state_q, state_d;
    owner_e             last_owner_q, last_owner_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic               req_i, req_d, acc_i, acc_d, acc_rd, acc_wr;
    logic [ADDR_W-1:0]  acc_idx;
    logic [DATA_W-1:0]  rd_data;
    logic               pipe_vld, pipe_busy;
    owner_e             pipe_owner;
    logic               unused_addr_lsb;

    assign unused_addr_lsb = i_addr[0] ^ d_addr[0];

    assign req_i   = i_read_req;
    assign req_d   = d_read_req | d_wrt_mem;
    assign acc_i   = (state_q == StOwnI) & req_i;
    assign acc_d   = (state_q == StOwnD) & req_d;
    assign i_stall = req_i & ~acc_i;
    assign d_stall = req_d & ~acc_d;

    assign acc_rd  = acc_i | (acc_d & d_read_req);
    assign acc_wr  = acc_d & d_wrt_mem & ~d_read_req;
    assign acc_idx = acc_d ? d_addr[ADDR_W:1] : i_addr[ADDR_W:1];
    assign rd_data = mem_q[acc_idx];
    assign cnt_inc = burst_cnt_q + CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        unique case (state_q)
            StIdle: begin
                // On a tie, the port that did not own last goes first.
                if (req_i && req_d) begin
                    state_d = (last_owner_q == OwnerI) ? StOwnD : StOwnI;
                end else if (req_i) begin
                    state_d = StOwnI;
                end else if (req_d) begin
                    state_d = StOwnD;
                end
            end
            StOwnI, StOwnD: begin
                if ((state_q == StOwnI) ? acc_i : acc_d) begin
                    burst_cnt_d = cnt_inc;
                end
                if (!((state_q == StOwnI) ? req_i : req_d) ||
                    (burst_cnt_d == CNT_W'(MAX_BURST))) begin
                    state_d      = StDrain;
                    last_owner_d = (state_q == StOwnI) ? OwnerI : OwnerD;
                    burst_cnt_d  = '0;
                end
            end
            StDrain: begin
                if (!pipe_busy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            last_owner_q <= OwnerI;
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    // Backing store is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (rst && acc_wr) begin
            mem_q[acc_idx] <= d_wdata;
        end
    end

    cache_mem_responder_resp_pipe #(
        .LATENCY(LATENCY)
    ) u_resp_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (acc_rd),
        .in_owner (acc_d ? OwnerD : OwnerI),
        .in_data  (rd_data),
        .out_vld  (pipe_vld),
        .out_owner(pipe_owner),
        .out_data (mem_data),
        .any_valid(pipe_busy)
    );

    assign i_mem_data_vld = pipe_vld & (pipe_owner == OwnerI);
    assign d_mem_data_vld = pipe_vld & (pipe_owner == OwnerD);

endmodule
